// File: rtl/rfsoc_config.sv
// Shared configuration constants for the RFSoC DAC playback path: gpio bit
// indices of the serial config bus, counter width and the playback state type.
package rfsoc_config;

   localparam int config_reg_width = 16;

   // Bit positions inside gpio_ctrl; every *_clk bit strobes one shift register.
   localparam int mask_clk             = 0;
   localparam int sdata                = 1;
   localparam int cycle_count_clk      = 2;
   localparam int pre_delay_cycle_clk  = 3;
   localparam int post_delay_cycle_clk = 4;
   localparam int locking_waveform_clk = 5;
   localparam int repeat_count_clk     = 6;
   localparam int mode_clk             = 7;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      RUN,
      TAIL,
      POST,
      WAIT_LOW
   } playback_state_t;

endpackage

// File: rtl/shift_register.sv
// Serial-in parallel-out config register, MSB shifted in first.
module shift_register #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         shift,
   input  logic         din,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) q <= '0;
      else if (shift) q <= {q[W-2:0], din};
   end

endmodule

// File: rtl/dac_playback_ctrl.sv
// Triggered burst playback from the looping waveform FIFO into one DAC stream,
// with pre-delay, repeats, post-gap, edge masking and a between-burst locking word.
module dac_playback_ctrl import rfsoc_config::*; #(
   parameter int DATA_W = 256,
   parameter int CNT_W  = config_reg_width
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [DATA_W-1:0]     m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic [DATA_W-1:0]     s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [15:0]           gpio_ctrl_ext,
   input  logic                  select_in,
   input  logic                  trigger_in,
   output logic                  mux_sel,
   output logic                  loopback_valid,
   output logic                  busy,
   output logic                  underrun,
   output playback_state_t       state_dbg
);

   // FIFO handshake: a word moves whenever s_axis_tready and s_axis_tvalid are
   // both high on a clk edge; the DAC side never stalls, so tvalid is tied high.

   logic [15:0]       gpio_q;
   logic [7:0]        sclk_now, sclk_prev, shift_en;
   logic [DATA_W-1:0] mask_r, lock_r;
   logic [CNT_W-1:0]  cycle_r, pre_r, post_r, rep_r;
   logic [7:0]        mode_r;

   // Strobe bits are sampled in the clk domain and edge-detected into shift enables.
   assign sclk_now = gpio_q[7:0] & {8{select_in}};
   assign shift_en = sclk_now & ~sclk_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gpio_q    <= '0;
         sclk_prev <= '0;
      end else begin
         gpio_q    <= gpio_ctrl_ext;
         sclk_prev <= sclk_now;
      end
   end

   shift_register #(.W(DATA_W)) u_mask  (.clk(clk), .rst(rst), .shift(shift_en[mask_clk]),             .din(gpio_q[sdata]), .q(mask_r));
   shift_register #(.W(CNT_W))  u_cycle (.clk(clk), .rst(rst), .shift(shift_en[cycle_count_clk]),      .din(gpio_q[sdata]), .q(cycle_r));
   shift_register #(.W(CNT_W))  u_pre   (.clk(clk), .rst(rst), .shift(shift_en[pre_delay_cycle_clk]),  .din(gpio_q[sdata]), .q(pre_r));
   shift_register #(.W(CNT_W))  u_post  (.clk(clk), .rst(rst), .shift(shift_en[post_delay_cycle_clk]), .din(gpio_q[sdata]), .q(post_r));
   shift_register #(.W(DATA_W)) u_lock  (.clk(clk), .rst(rst), .shift(shift_en[locking_waveform_clk]), .din(gpio_q[sdata]), .q(lock_r));
   shift_register #(.W(CNT_W))  u_rep   (.clk(clk), .rst(rst), .shift(shift_en[repeat_count_clk]),     .din(gpio_q[sdata]), .q(rep_r));
   shift_register #(.W(8))      u_mode  (.clk(clk), .rst(rst), .shift(shift_en[mode_clk]),             .din(gpio_q[sdata]), .q(mode_r));

   logic unused_ok;
   assign unused_ok = ^{m_axis_tready, gpio_q[15:8], shift_en[sdata], mode_r[7:4]};

   playback_state_t   state;
   logic [CNT_W-1:0]  cnt, rep_left, s_cycle, s_post;
   logic [DATA_W-1:0] s_mask, first_word, out_q;
   logic              s_mask_en, s_edge, first, trig_q, trig_d, underrun_q;

   logic              arm;
   logic [DATA_W-1:0] rd_word, idle_word;
   playback_state_t   done_state, fin_state;
   logic [CNT_W-1:0]  fin_cnt, fin_rep;
   logic              fin_first;

   assign arm       = mode_r[2] ? (trig_q & ~trig_d) : trigger_in;
   assign rd_word   = s_axis_tvalid ? s_axis_tdata : '0;
   assign idle_word = mode_r[3] ? lock_r : '0;
   // WAIT_LOW is only worth entering when a level trigger is still held.
   assign done_state = (!s_edge && trigger_in) ? WAIT_LOW : IDLE;

   // Where a repeat goes once its reads (and optional tail word) are done.
   always_comb begin
      fin_state = done_state;
      fin_cnt   = cnt;
      fin_rep   = rep_left;
      fin_first = 1'b0;
      if (s_post != '0) begin
         fin_state = POST;
         fin_cnt   = s_post;
      end else if (rep_left != '0) begin
         fin_state = RUN;
         fin_cnt   = s_cycle;
         fin_rep   = rep_left - CNT_W'(1);
         fin_first = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         rep_left   <= '0;
         s_cycle    <= '0;
         s_post     <= '0;
         s_mask     <= '0;
         s_mask_en  <= 1'b0;
         s_edge     <= 1'b0;
         first      <= 1'b0;
         first_word <= '0;
         out_q      <= '0;
         underrun_q <= 1'b0;
         trig_q     <= 1'b0;
         trig_d     <= 1'b0;
      end else begin
         trig_q <= trigger_in;
         trig_d <= trig_q;
         case (state)
            IDLE: begin
               out_q <= idle_word;
               if (arm && cycle_r != '0) begin
                  s_cycle   <= cycle_r;
                  s_post    <= post_r;
                  rep_left  <= rep_r;
                  s_mask    <= mask_r;
                  s_mask_en <= mode_r[0];
                  s_edge    <= mode_r[2];
                  if (pre_r != '0) begin
                     state <= PRE;
                     cnt   <= pre_r;
                  end else begin
                     state <= RUN;
                     cnt   <= cycle_r;
                     first <= 1'b1;
                  end
               end
            end
            PRE: begin
               out_q <= '0;
               if (cnt == CNT_W'(1)) begin
                  state <= RUN;
                  cnt   <= s_cycle;
                  first <= 1'b1;
               end else cnt <= cnt - CNT_W'(1);
            end
            RUN: begin
               first <= 1'b0;
               if (!s_axis_tvalid) underrun_q <= 1'b1;
               if (first) first_word <= rd_word;
               out_q <= (first && s_mask_en) ? (rd_word & s_mask) : rd_word;
               if (cnt == CNT_W'(1)) begin
                  if (s_mask_en) state <= TAIL;
                  else begin
                     state    <= fin_state;
                     cnt      <= fin_cnt;
                     rep_left <= fin_rep;
                     first    <= fin_first;
                  end
               end else cnt <= cnt - CNT_W'(1);
            end
            TAIL: begin
               out_q    <= first_word & ~s_mask;
               state    <= fin_state;
               cnt      <= fin_cnt;
               rep_left <= fin_rep;
               first    <= fin_first;
            end
            POST: begin
               out_q <= '0;
               if (cnt == CNT_W'(1)) begin
                  if (rep_left != '0) begin
                     rep_left <= rep_left - CNT_W'(1);
                     state    <= RUN;
                     cnt      <= s_cycle;
                     first    <= 1'b1;
                  end else state <= done_state;
               end else cnt <= cnt - CNT_W'(1);
            end
            WAIT_LOW: begin
               out_q <= idle_word;
               if (s_edge || !trigger_in) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign m_axis_tdata   = out_q;
   assign m_axis_tvalid  = 1'b1;
   assign s_axis_tready  = (state == RUN);
   assign loopback_valid = s_axis_tready & s_axis_tvalid;
   assign busy           = (state != IDLE);
   assign underrun       = underrun_q;
   assign mux_sel        = mode_r[1];
   assign state_dbg      = state;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed checks of dac_playback_ctrl: config shifting, burst timing, masking,
// repeats, edge triggering, underrun and reset/snapshot behaviour.
module tb_dac_playback_ctrl;
   import rfsoc_config::*;

   localparam int DW = 32;
   localparam int CW = 16;

   logic            clk, rst;
   logic [DW-1:0]   m_axis_tdata, s_axis_tdata;
   logic            m_axis_tvalid, m_axis_tready, s_axis_tvalid, s_axis_tready;
   logic [15:0]     gpio_ctrl_ext;
   logic            select_in, trigger_in, mux_sel, loopback_valid, busy, underrun;
   playback_state_t state_dbg;

   int vectors = 0;
   int errors  = 0;

   logic [DW-1:0] src [128];
   int   rd_idx, read_no, drop_read, lb_count;
   logic consume;

   dac_playback_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .gpio_ctrl_ext(gpio_ctrl_ext), .select_in(select_in), .trigger_in(trigger_in),
      .mux_sel(mux_sel), .loopback_valid(loopback_valid), .busy(busy), .underrun(underrun),
      .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: FIFO model pops consumed word, presents next, then samples at negedge+1.
   task automatic tick();
      @(negedge clk);
      if (consume) rd_idx = (rd_idx + 1) % 128;
      if (s_axis_tready) read_no++;
      s_axis_tvalid = !(s_axis_tready && read_no == drop_read);
      s_axis_tdata  = src[rd_idx];
      consume       = s_axis_tready && s_axis_tvalid;
      #1;
      if (loopback_valid) lb_count++;
   endtask

   task automatic fifo_reset();
      for (int i = 0; i < 128; i++) src[i] = 32'hC0DE_0000 + DW'(i);
      rd_idx = 0; read_no = 0; drop_read = -1; lb_count = 0; consume = 1'b0;
   endtask

   task automatic shift_bits(input int idx, input logic [DW-1:0] val, input int width);
      for (int i = width - 1; i >= 0; i--) begin
         gpio_ctrl_ext[sdata] = val[i];
         gpio_ctrl_ext[idx]   = 1'b0;
         tick(); tick();
         gpio_ctrl_ext[idx]   = 1'b1;
         tick(); tick();
      end
      gpio_ctrl_ext[idx] = 1'b0;
      tick(); tick();
   endtask

   task automatic cfg(input logic [DW-1:0] mask, input logic [CW-1:0] cyc, input logic [CW-1:0] pre,
                      input logic [CW-1:0] post, input logic [CW-1:0] rep, input logic [DW-1:0] lock,
                      input logic [7:0] mode);
      shift_bits(mask_clk, mask, DW);
      shift_bits(cycle_count_clk, DW'(cyc), CW);
      shift_bits(pre_delay_cycle_clk, DW'(pre), CW);
      shift_bits(post_delay_cycle_clk, DW'(post), CW);
      shift_bits(repeat_count_clk, DW'(rep), CW);
      shift_bits(locking_waveform_clk, lock, DW);
      shift_bits(mode_clk, DW'(mode), 8);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      vectors++;
      if ({m_axis_tdata, s_axis_tready, loopback_valid, busy, underrun, mux_sel} !== '0 ||
          state_dbg !== IDLE || m_axis_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL reset: tdata=%h rdy=%b lb=%b busy=%b und=%b mux=%b st=%0d tvalid=%b expected all 0, IDLE, tvalid 1",
                  m_axis_tdata, s_axis_tready, loopback_valid, busy, underrun, mux_sel, state_dbg, m_axis_tvalid);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_level_basic();
      logic [DW-1:0] L, d [1:7], ed [1:7];
      logic r [1:7], b [1:7], er [1:7], eb [1:7];
      L = 32'h5A5A_C3C3;
      fifo_reset();
      src[0] = 32'h1111_000A; src[1] = 32'h2222_000B; src[2] = 32'h3333_000C; src[3] = 32'h4444_000D;
      cfg('0, 16'd4, 16'd0, 16'd0, 16'd0, L, 8'h0A);
      lb_count = 0;
      trigger_in = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         if (i == 7) trigger_in = 1'b0;
         tick();
         d[i] = m_axis_tdata; r[i] = s_axis_tready; b[i] = busy;
      end
      ed = '{L, src[0], src[1], src[2], src[3], L, L};
      er = '{1, 1, 1, 1, 0, 0, 0};
      eb = '{1, 1, 1, 1, 1, 1, 0};
      for (int i = 1; i <= 7; i++) begin
         vectors++;
         if (d[i] !== ed[i] || r[i] !== er[i] || b[i] !== eb[i]) begin
            errors++;
            $display("FAIL level_basic[%0d]: data=%h rdy=%b busy=%b expected data=%h rdy=%b busy=%b",
                     i, d[i], r[i], b[i], ed[i], er[i], eb[i]);
         end
      end
      vectors++;
      if (lb_count !== 4 || mux_sel !== 1'b1) begin
         errors++;
         $display("FAIL level_basic_lb: loopback=%0d mux_sel=%b expected 4 and 1", lb_count, mux_sel);
      end
   endtask

   task automatic test_mask();
      logic [DW-1:0] M, d [1:6], ed [1:6];
      logic r [1:6], b [1:6], er [1:6], eb [1:6];
      M = 32'h00FF_00FF;
      fifo_reset();
      src[0] = 32'hDEAD_BEEF; src[1] = 32'h1234_5678; src[2] = 32'hCAFE_F00D;
      cfg(M, 16'd3, 16'd0, 16'd0, 16'd0, 32'hFFFF_FFFF, 8'h01);
      trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0;
      d[1] = m_axis_tdata; r[1] = s_axis_tready; b[1] = busy;
      for (int i = 2; i <= 6; i++) begin
         tick();
         d[i] = m_axis_tdata; r[i] = s_axis_tready; b[i] = busy;
      end
      ed = '{32'h0, 32'h00AD_00EF, 32'h1234_5678, 32'hCAFE_F00D, 32'hDE00_BE00, 32'h0};
      er = '{1, 1, 1, 0, 0, 0};
      eb = '{1, 1, 1, 1, 0, 0};
      for (int i = 1; i <= 6; i++) begin
         vectors++;
         if (d[i] !== ed[i] || r[i] !== er[i] || b[i] !== eb[i]) begin
            errors++;
            $display("FAIL mask[%0d]: data=%h rdy=%b busy=%b expected data=%h rdy=%b busy=%b",
                     i, d[i], r[i], b[i], ed[i], er[i], eb[i]);
         end
      end
   endtask

   task automatic test_repeat_delay();
      logic [DW-1:0] L, d [1:19], ed [1:19];
      logic b [1:19];
      int   nbusy;
      L = 32'h0F0F_A5A5;
      fifo_reset();
      cfg('0, 16'd2, 16'd5, 16'd2, 16'd2, L, 8'h08);
      lb_count = 0;
      nbusy    = 0;
      trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0;
      d[1] = m_axis_tdata; b[1] = busy;
      for (int i = 2; i <= 19; i++) begin
         tick();
         d[i] = m_axis_tdata; b[i] = busy;
      end
      for (int i = 1; i <= 19; i++) begin
         ed[i] = '0;
         if (b[i]) nbusy++;
      end
      ed[1] = L; ed[19] = L;
      ed[7] = src[0]; ed[8] = src[1]; ed[11] = src[2]; ed[12] = src[3]; ed[15] = src[4]; ed[16] = src[5];
      for (int i = 1; i <= 19; i++) begin
         vectors++;
         if (d[i] !== ed[i]) begin
            errors++;
            $display("FAIL repeat_delay[%0d]: data=%h expected %h", i, d[i], ed[i]);
         end
      end
      vectors++;
      if (nbusy !== 17 || b[17] !== 1'b1 || b[18] !== 1'b0 || lb_count !== 6) begin
         errors++;
         $display("FAIL repeat_delay_span: busy_cycles=%0d last=%b/%b reads=%0d expected 17 1/0 6",
                  nbusy, b[17], b[18], lb_count);
      end
   endtask

   task automatic test_edge_trigger();
      int nb;
      fifo_reset();
      cfg('0, 16'd3, 16'd0, 16'd0, 16'd0, '0, 8'h04);
      lb_count = 0; nb = 0;
      trigger_in = 1'b1;
      repeat (100) begin tick(); if (busy) nb++; end
      trigger_in = 1'b0;
      repeat (5) tick();
      vectors++;
      if (lb_count !== 3 || nb !== 3) begin
         errors++;
         $display("FAIL edge_first: reads=%0d busy_cycles=%0d expected 3 and 3", lb_count, nb);
      end
      lb_count = 0; nb = 0;
      trigger_in = 1'b1;
      repeat (20) begin tick(); if (busy) nb++; end
      trigger_in = 1'b0;
      tick();
      vectors++;
      if (lb_count !== 3 || nb !== 3) begin
         errors++;
         $display("FAIL edge_second: reads=%0d busy_cycles=%0d expected 3 and 3", lb_count, nb);
      end
   endtask

   task automatic test_underrun();
      logic [DW-1:0] d [1:5], ed [1:5];
      logic r [1:5], u [1:5], b5, er [1:5], eu [1:5];
      fifo_reset();
      cfg('0, 16'd4, 16'd0, 16'd0, 16'd0, '0, 8'h00);
      read_no = 0; drop_read = 2;
      trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0;
      d[1] = m_axis_tdata; r[1] = s_axis_tready; u[1] = underrun;
      for (int i = 2; i <= 5; i++) begin
         tick();
         d[i] = m_axis_tdata; r[i] = s_axis_tready; u[i] = underrun;
      end
      b5 = busy;
      ed = '{32'h0, src[0], 32'h0, src[1], src[2]};
      er = '{1, 1, 1, 1, 0};
      eu = '{0, 0, 1, 1, 1};
      for (int i = 1; i <= 5; i++) begin
         vectors++;
         if (d[i] !== ed[i] || r[i] !== er[i] || u[i] !== eu[i]) begin
            errors++;
            $display("FAIL underrun[%0d]: data=%h rdy=%b und=%b expected data=%h rdy=%b und=%b",
                     i, d[i], r[i], u[i], ed[i], er[i], eu[i]);
         end
      end
      drop_read = -1;
      repeat (10) tick();
      vectors++;
      if (b5 !== 1'b0 || underrun !== 1'b1) begin
         errors++;
         $display("FAIL underrun_sticky: busy_after_4=%b underrun=%b expected 0 and 1", b5, underrun);
      end
   endtask

   task automatic test_reset_and_snapshot();
      int guard;
      fifo_reset();
      cfg('0, 16'd8, 16'd0, 16'd0, 16'd0, 32'h1234_4321, 8'h0A);
      trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if ({m_axis_tdata, s_axis_tready, loopback_valid, busy, underrun, mux_sel} !== '0 || state_dbg !== IDLE) begin
         errors++;
         $display("FAIL reset_mid_run: tdata=%h rdy=%b lb=%b busy=%b und=%b mux=%b st=%0d expected all 0, IDLE",
                  m_axis_tdata, s_axis_tready, loopback_valid, busy, underrun, mux_sel, state_dbg);
      end
      tick();
      rst = 1'b1;
      fifo_reset();
      tick();
      cfg('0, 16'd80, 16'd0, 16'd0, 16'd0, '0, 8'h00);
      lb_count = 0;
      trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0;
      shift_bits(cycle_count_clk, 32'd3, CW);
      guard = 0;
      while (busy && guard < 200) begin tick(); guard++; end
      vectors++;
      if (busy || lb_count !== 80) begin
         errors++;
         $display("FAIL snapshot_len: busy=%b reads=%0d expected 0 and 80", busy, lb_count);
      end
      lb_count = 0;
      trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0;
      repeat (10) tick();
      vectors++;
      if (busy || lb_count !== 3) begin
         errors++;
         $display("FAIL snapshot_next: busy=%b reads=%0d expected 0 and 3", busy, lb_count);
      end
   endtask

   initial begin
      rst = 1'b0;
      gpio_ctrl_ext = '0;
      select_in = 1'b1;
      trigger_in = 1'b0;
      m_axis_tready = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata = '0;
      fifo_reset();
      test_reset();
      test_level_basic();
      test_mask();
      test_repeat_delay();
      test_edge_trigger();
      test_underrun();
      test_reset_and_snapshot();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
